// File: rtl/run_step_ctrl.sv
// run_step_ctrl
// Execution controller that sits directly after the push-button debouncer.
// Every change of the debounced level is one press. A press in IDLE starts
// free-running execution or a fixed-length single-step burst. A CPU halt
// request moves the controller into a sticky HALT state. The block also keeps
// a saturating count of clock-enabled cycles for the display logic.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   toggle_in    debounced button level; each change is one press
//   step_mode    1 = single-step, 0 = free-run; sampled only on a press in IDLE
//   halt_req     CPU halt request (level)
//   cpu_en       pipeline clock-enable
//   running      high while free-running
//   halted       high while halted (sticky until reset)
//   press_pulse  one-cycle pulse for every detected press, accepted or not
//   cycle_cnt    saturating count of cycles with cpu_en=1 since reset

module run_step_ctrl #(
    parameter int STEP_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             toggle_in,
    input  logic             step_mode,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic             press_pulse,
    output logic [CNT_W-1:0] cycle_cnt
);

    // A zero step length would give an empty burst; it is treated as 1.
    // Values above the 8-bit counter range are clamped.
    localparam logic [7:0] STEP_LOAD =
        (STEP_CYCLES < 1)   ? 8'd1   :
        (STEP_CYCLES > 255) ? 8'd255 : 8'(STEP_CYCLES);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [7:0]       step_cnt_reg;
    logic [7:0]       step_cnt_next;
    logic             prev_toggle_reg;
    logic             press_pulse_reg;
    logic [CNT_W-1:0] cycle_cnt_reg;
    logic             press;

    // prev_toggle resets to the debouncer's reset level (0) so that no
    // spurious press is seen when reset is released.
    assign press = toggle_in ^ prev_toggle_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            step_cnt_reg    <= 8'd0;
            prev_toggle_reg <= 1'b0;
            press_pulse_reg <= 1'b0;
            cycle_cnt_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            step_cnt_reg    <= step_cnt_next;
            prev_toggle_reg <= toggle_in;
            press_pulse_reg <= press;
            // Count edges at which the enable was active; hold at full scale.
            if (cpu_en && (cycle_cnt_reg != CNT_MAX)) begin
                cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        step_cnt_next = step_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                // halt_req is deliberately ignored while the CPU is stopped.
                if (press) begin
                    if (step_mode) begin
                        state_next    = ST_STEP;
                        step_cnt_next = STEP_LOAD;
                    end else begin
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // A halt in the same cycle as a press wins over the pause.
                if (halt_req) begin
                    state_next = ST_HALT;
                end else if (press) begin
                    state_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                // The counter holds the number of enabled cycles remaining,
                // including the current one; leaving at 1 gives exactly
                // STEP_LOAD enabled cycles. Presses are ignored here.
                if (halt_req) begin
                    state_next    = ST_HALT;
                    step_cnt_next = 8'd0;
                end else if (step_cnt_reg <= 8'd1) begin
                    state_next    = ST_IDLE;
                    step_cnt_next = 8'd0;
                end else begin
                    step_cnt_next = step_cnt_reg - 8'd1;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next    = ST_IDLE;
                step_cnt_next = 8'd0;
            end
        endcase
    end

    // Pure decodes of the registered state: no input-to-output paths, and
    // the async reset removes the enable immediately.
    assign cpu_en      = (state_reg == ST_RUN) || (state_reg == ST_STEP);
    assign running     = (state_reg == ST_RUN);
    assign halted      = (state_reg == ST_HALT);
    assign press_pulse = press_pulse_reg;
    assign cycle_cnt   = cycle_cnt_reg;

endmodule

// File: tb/tb_run_step_ctrl.sv
// Testbench for run_step_ctrl. Two instances share the stimulus:
// dut_a (STEP_CYCLES=3, CNT_W=16) and dut_b (STEP_CYCLES=4, CNT_W=4).
module tb_run_step_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic toggle_in;
    logic step_mode;
    logic halt_req;

    logic        en_a, run_a, hlt_a, pp_a;
    logic [15:0] cnt_a;
    logic        en_b, run_b, hlt_b, pp_b;
    logic [3:0]  cnt_b;

    run_step_ctrl #(.STEP_CYCLES(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .toggle_in(toggle_in), .step_mode(step_mode),
        .halt_req(halt_req), .cpu_en(en_a), .running(run_a), .halted(hlt_a),
        .press_pulse(pp_a), .cycle_cnt(cnt_a)
    );

    run_step_ctrl #(.STEP_CYCLES(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .toggle_in(toggle_in), .step_mode(step_mode),
        .halt_req(halt_req), .cpu_en(en_b), .running(run_b), .halted(hlt_b),
        .press_pulse(pp_b), .cycle_cnt(cnt_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The controller is described by what it is doing: free-running, burning
    // a number of remaining step cycles, halted, or none of these (idle).
    typedef struct {
        bit halted;
        bit running;
        int steps_left;
        bit prev;
        bit pulse;
        int cnt;
    } model_t;

    model_t m[2];
    int step_len[2] = '{3, 4};
    int cnt_max[2]  = '{65535, 15};

    function automatic bit m_en(input model_t s);
        return s.running || (s.steps_left > 0);
    endfunction

    function automatic model_t model_reset();
        model_t s;
        s.halted = 0; s.running = 0; s.steps_left = 0;
        s.prev = 0; s.pulse = 0; s.cnt = 0;
        return s;
    endfunction

    function automatic model_t model_next(input model_t s, input int n, input int mx,
                                          input bit tog, input bit sm, input bit hr);
        model_t r = s;
        bit press = tog ^ s.prev;
        bit en = m_en(s);
        if (en) r.cnt = (s.cnt + 1 > mx) ? mx : s.cnt + 1;
        r.pulse = press;
        r.prev  = tog;
        if (s.halted) begin
            // stays halted
        end else if (en && hr) begin
            r.halted = 1; r.running = 0; r.steps_left = 0;
        end else if (s.running) begin
            if (press) r.running = 0;
        end else if (s.steps_left > 0) begin
            r.steps_left = s.steps_left - 1;
        end else if (press) begin
            if (sm) r.steps_left = n;
            else    r.running = 1;
        end
        return r;
    endfunction

    task automatic compare_model();
        chk("a_cpu_en",  int'(en_a),  int'(m_en(m[0])));
        chk("a_running", int'(run_a), int'(m[0].running));
        chk("a_halted",  int'(hlt_a), int'(m[0].halted));
        chk("a_pulse",   int'(pp_a),  int'(m[0].pulse));
        chk("a_cnt",     int'(cnt_a), m[0].cnt);
        chk("b_cpu_en",  int'(en_b),  int'(m_en(m[1])));
        chk("b_running", int'(run_b), int'(m[1].running));
        chk("b_halted",  int'(hlt_b), int'(m[1].halted));
        chk("b_pulse",   int'(pp_b),  int'(m[1].pulse));
        chk("b_cnt",     int'(cnt_b), m[1].cnt);
    endtask

    // One clock: predict from current inputs, advance, compare 1 ns later.
    task automatic tick();
        for (int k = 0; k < 2; k++)
            m[k] = model_next(m[k], step_len[k], cnt_max[k], toggle_in, step_mode, halt_req);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        toggle_in = 1'b0;
        halt_req = 1'b0;
        #1;
        // Reset acts without waiting for a clock edge.
        chk("rst_async_en_a", int'(en_a), 0);
        chk("rst_async_en_b", int'(en_b), 0);
        chk("rst_async_cnt_a", int'(cnt_a), 0);
        m[0] = model_reset();
        m[1] = model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        compare_model();
    endtask

    typedef struct {
        bit tog; bit sm; bit hr;
        bit en; bit run; bit hlt; bit pp; int cnt;
    } vec_t;
    vec_t tbl[11];

    int en_sum;
    int burst;

    initial begin
        rst_n = 1'b0; toggle_in = 1'b0; step_mode = 1'b0; halt_req = 1'b0;
        m[0] = model_reset();
        m[1] = model_reset();

        // Expected dut_a outputs after the edge following each input row.
        tbl[0]  = '{0, 1, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{1, 1, 0,  1, 0, 0, 1, 0};  // press -> STEP (3)
        tbl[2]  = '{1, 1, 0,  1, 0, 0, 0, 1};
        tbl[3]  = '{1, 1, 0,  1, 0, 0, 0, 2};
        tbl[4]  = '{1, 1, 0,  0, 0, 0, 0, 3};  // burst of 3 done
        tbl[5]  = '{1, 1, 0,  0, 0, 0, 0, 3};
        tbl[6]  = '{0, 0, 0,  1, 1, 0, 1, 3};  // press -> RUN
        tbl[7]  = '{0, 0, 0,  1, 1, 0, 0, 4};
        tbl[8]  = '{1, 0, 1,  0, 0, 1, 1, 5};  // halt + press together -> HALT
        tbl[9]  = '{0, 0, 0,  0, 0, 1, 1, 5};  // press ignored in HALT
        tbl[10] = '{0, 0, 0,  0, 0, 1, 0, 5};

        do_reset();
        chk("reset_running", int'(run_a), 0);
        chk("reset_halted",  int'(hlt_a), 0);
        chk("reset_pulse",   int'(pp_a),  0);

        for (int i = 0; i < 11; i++) begin
            toggle_in = tbl[i].tog; step_mode = tbl[i].sm; halt_req = tbl[i].hr;
            tick();
            chk($sformatf("tbl%0d_en", i),  int'(en_a),  int'(tbl[i].en));
            chk($sformatf("tbl%0d_run", i), int'(run_a), int'(tbl[i].run));
            chk($sformatf("tbl%0d_hlt", i), int'(hlt_a), int'(tbl[i].hlt));
            chk($sformatf("tbl%0d_pp", i),  int'(pp_a),  int'(tbl[i].pp));
            chk($sformatf("tbl%0d_cnt", i), int'(cnt_a), tbl[i].cnt);
        end
        halt_req = 1'b0;

        // Free run for 10 cycles, then pause.
        do_reset();
        step_mode = 1'b0; toggle_in = 1'b1;
        tick();
        chk("run_start_pulse", int'(pp_a), 1);
        chk("run_start_en", int'(en_a), 1);
        chk("run_start_running", int'(run_a), 1);
        for (int i = 0; i < 10; i++) tick();
        chk("run_cnt10", int'(cnt_a), 10);
        chk("run_pulse_gone", int'(pp_a), 0);
        toggle_in = 1'b0;
        tick();
        chk("pause_en", int'(en_a), 0);
        for (int i = 0; i < 3; i++) tick();
        chk("pause_cnt_hold", int'(cnt_a), 11);

        // Three single-step bursts of 3.
        do_reset();
        step_mode = 1'b1;
        for (int b = 0; b < 3; b++) begin
            toggle_in = ~toggle_in;
            burst = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                burst += int'(en_a);
                chk("step_not_running", int'(run_a), 0);
            end
            chk("step_burst_len", burst, 3);
        end
        chk("step_cnt9", int'(cnt_a), 9);

        // Halt is sticky; only reset leaves it.
        do_reset();
        step_mode = 1'b0; toggle_in = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        halt_req = 1'b1;
        tick();
        chk("halt_en", int'(en_a), 0);
        chk("halt_flag", int'(hlt_a), 1);
        halt_req = 1'b0;
        for (int i = 0; i < 2; i++) begin
            toggle_in = ~toggle_in;
            tick();
            chk("halt_press_pulse", int'(pp_a), 1);
            chk("halt_sticky", int'(hlt_a), 1);
            tick();
        end
        do_reset();
        chk("halt_reset_flag", int'(hlt_a), 0);

        // dut_b: press during a 4-cycle burst is ignored.
        do_reset();
        step_mode = 1'b1; toggle_in = 1'b1;
        en_sum = 0;
        tick(); en_sum += int'(en_b);
        tick(); en_sum += int'(en_b);
        toggle_in = 1'b0;
        tick(); en_sum += int'(en_b);
        chk("burst_press_pulse", int'(pp_b), 1);
        for (int i = 0; i < 8; i++) begin
            tick(); en_sum += int'(en_b);
        end
        chk("burst4_len", en_sum, 4);
        chk("burst4_cnt", int'(cnt_b), 4);
        // Halt during the 2nd burst cycle.
        do_reset();
        toggle_in = 1'b1;
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        chk("burst_halt_flag", int'(hlt_b), 1);
        chk("burst_halt_cnt", int'(cnt_b), 2);

        // Saturation on the 4-bit counter, then async reset mid-run.
        do_reset();
        step_mode = 1'b0; toggle_in = 1'b1;
        for (int i = 0; i < 21; i++) tick();
        chk("sat_cnt_b", int'(cnt_b), 15);
        chk("sat_cnt_a", int'(cnt_a), 20);
        chk("sat_still_running", int'(en_b), 1);
        do_reset();

        // Randomised run against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                if ($urandom_range(0, 5) == 0) toggle_in = ~toggle_in;
                step_mode = 1'($urandom_range(0, 1));
                halt_req = ($urandom_range(0, 39) == 0);
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/run_step_ctrl.md
Name: run_step_ctrl

Overview:
Execution controller directly downstream of the push-button debouncer. It consumes the debouncer's toggling level output, turns each toggle into a press event, and drives the pipeline clock-enable. Modes are free-running, fixed-length single-step, and sticky halt on a CPU halt request. It also keeps a saturating count of enabled cycles for the display logic.

Parameters:
STEP_CYCLES, 1, number of consecutive cpu_en cycles per single-step press; legal range 1..255
CNT_W, 16, width of the enabled-cycle counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
toggle_in  input  1  debounced button level; each change (0->1 or 1->0) is one press; driven from the clk domain, no synchronizer
step_mode  input  1  slide switch; 1 = single-step, 0 = free-run; sampled only on a press accepted in IDLE
halt_req  input  1  CPU halt request (halt instruction retired); level
cpu_en  output  1  pipeline clock-enable
running  output  1  1 while state is RUN
halted  output  1  1 while state is HALT
press_pulse  output  1  one-cycle pulse on every detected press, accepted or ignored
cycle_cnt  output  CNT_W  number of cycles with cpu_en=1 since reset, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE, prev_toggle=0, step counter=0, cycle_cnt=0. All outputs are 0.
- prev_toggle matches the debouncer's reset level, so no spurious press occurs after reset.
- Press detect: press = toggle_in XOR prev_toggle. prev_toggle <= toggle_in every cycle. press_pulse is registered and is high for the one cycle after the edge where press was seen.
- States:
  - IDLE (cpu_en=0).
    - press with step_mode=1 -> STEP, step counter loaded with STEP_CYCLES.
    - press with step_mode=0 -> RUN.
    - halt_req is ignored in IDLE.
  - RUN (cpu_en=1, running=1).
    - halt_req=1 -> HALT.
    - Otherwise press -> IDLE (pause).
    - halt_req has priority over a press in the same cycle.
  - STEP (cpu_en=1).
    - The step counter decrements each cycle.
    - When the counter is 1 and decrementing -> IDLE, so cpu_en is high for exactly STEP_CYCLES cycles.
    - halt_req=1 -> HALT immediately; halt_req has priority over counter expiry.
    - Presses are ignored but still pulse press_pulse.
  - HALT (cpu_en=0, halted=1).
    - Sticky; only rst_n leaves it.
    - Presses are ignored but still pulse press_pulse.
- cpu_en, running and halted are pure decodes of the registered state (no combinational path from inputs).
- Latency: toggle_in changes at edge E -> press seen during cycle E..E+1 -> state updates at E+1 -> cpu_en high from E+1.
- halt_req is seen at edge E while cpu_en=1 -> cpu_en low from E.
- cycle_cnt increments on each edge where cpu_en=1. It holds at 2^CNT_W-1 (no wrap).
- The step counter is 8 bits wide. STEP_CYCLES=0 is illegal; the implementation treats it as 1.
- Reset mid-RUN or mid-STEP: cpu_en drops asynchronously and the counters clear.

Test Plan:
1. Reset, step_mode=0, toggle_in 0->1 -> press_pulse one cycle; cpu_en=1 and running=1 one cycle after the toggle; after 10 cycles cycle_cnt=10. Toggle 1->0 -> IDLE, cpu_en=0, cycle_cnt holds at final value.
2. STEP_CYCLES=3, step_mode=1, three toggles spaced 20 cycles apart -> three bursts of exactly 3 cpu_en cycles; cycle_cnt=9; running stays 0.
3. RUN, then assert halt_req -> cpu_en=0 next cycle, halted=1; subsequent toggles give press_pulse but the state stays HALT; rst_n pulse -> IDLE, cycle_cnt=0.
4. RUN, halt_req and a toggle in the same cycle -> HALT, not IDLE.
5. STEP_CYCLES=4 with a toggle during the burst -> burst still exactly 4 cycles, press_pulse=1, no extra step afterwards. halt_req at the 2nd burst cycle -> HALT, with cycle_cnt=2 for that burst.
6. CNT_W=4, free-run 20 cycles -> cycle_cnt saturates at 15. Separately, rst_n low mid-RUN -> cpu_en=0 immediately (asynchronously, before the next clk edge).
